// File: rtl/mu_stream_pack.sv
// Narrow-to-wide stream packer feeding the async FIFO write port.
// Collects RATIO input beats into one word; in_last closes a word early, zero-padded.
module mu_stream_pack #(
  parameter int DW_IN = 16,
  parameter int RATIO = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic [DW_IN-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [DW_IN*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int DW_OUT = DW_IN * RATIO;
  localparam int CW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  // RATIO == 1 never accumulates; one dummy lane keeps the declarations legal
  localparam int AL     = (RATIO > 1) ? RATIO - 1 : 1;

  logic [CW-1:0]            cnt;
  logic [AL-1:0][DW_IN-1:0] acc;
  logic [AL-1:0]            fill;
  logic                     accept;
  logic                     complete;
  logic [DW_OUT-1:0]        word;
  logic [RATIO-1:0]         keep;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign complete = accept & ((int'(cnt) == RATIO - 1) | in_last);

  // Word as it would load on a completing beat: filled lanes, current beat, zero above
  always_comb begin
    word = '0;
    keep = '0;
    for (int k = 0; k < AL; k++) begin
      if (k < int'(cnt) && fill[k]) word[k*DW_IN +: DW_IN] = acc[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (k <= int'(cnt)) keep[k] = 1'b1;
      if (k == int'(cnt)) word[k*DW_IN +: DW_IN] = in_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt       <= '0;
      acc       <= '0;
      fill      <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (complete) begin
      out_data  <= word;
      out_keep  <= keep;
      out_last  <= in_last;
      out_valid <= 1'b1;
      cnt       <= '0;
      fill      <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < AL; k++) begin
          if (int'(cnt) == k) begin
            acc[k]  <= in_data;
            fill[k] <= 1'b1;
          end
        end
        cnt <= cnt + 1'b1;
      end
      if (out_valid & out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mu_stream_pack.sv
// Bench for mu_stream_pack: RATIO 2, 4 and 1 instances against a beat-list model,
// plus literal expectations for the directed scenarios.
module tb_mu_stream_pack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nreset;
  logic [15:0] id   [3];
  logic        iv   [3];
  logic        il   [3];
  logic        ordy [3];

  logic [31:0] od2;
  logic [63:0] od4;
  logic [15:0] od1;
  logic [1:0]  ok2;
  logic [3:0]  ok4;
  logic        ok1;
  logic        u0_ir, u0_ol, u0_ov;
  logic        u1_ir, u1_ol, u1_ov;
  logic        u2_ir, u2_ol, u2_ov;

  int tests = 0;
  int fails = 0;

  mu_stream_pack #(.DW_IN(16), .RATIO(2)) u_r2 (
    .clk(clk), .nreset(nreset), .in_data(id[0]), .in_valid(iv[0]), .in_last(il[0]),
    .in_ready(u0_ir), .out_data(od2), .out_keep(ok2), .out_last(u0_ol),
    .out_valid(u0_ov), .out_ready(ordy[0]));

  mu_stream_pack #(.DW_IN(16), .RATIO(4)) u_r4 (
    .clk(clk), .nreset(nreset), .in_data(id[1]), .in_valid(iv[1]), .in_last(il[1]),
    .in_ready(u1_ir), .out_data(od4), .out_keep(ok4), .out_last(u1_ol),
    .out_valid(u1_ov), .out_ready(ordy[1]));

  mu_stream_pack #(.DW_IN(16), .RATIO(1)) u_r1 (
    .clk(clk), .nreset(nreset), .in_data(id[2]), .in_valid(iv[2]), .in_last(il[2]),
    .in_ready(u2_ir), .out_data(od1), .out_keep(ok1), .out_last(u2_ol),
    .out_valid(u2_ov), .out_ready(ordy[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sample(input int i, output logic [63:0] d, output logic [3:0] k,
                        output logic l, output logic v, output logic r);
    case (i)
      0: begin d = {32'b0, od2}; k = {2'b0, ok2}; l = u0_ol; v = u0_ov; r = u0_ir; end
      1: begin d = od4;          k = ok4;         l = u1_ol; v = u1_ov; r = u1_ir; end
      default: begin d = {48'b0, od1}; k = {3'b0, ok1}; l = u2_ol; v = u2_ov; r = u2_ir; end
    endcase
  endtask

  // Model: a word is the list of beats collected since the last word, packed LSB-first
  int          rat [3] = '{2, 4, 1};
  bit          m_valid [3];
  logic [63:0] m_data  [3];
  logic [3:0]  m_keep  [3];
  bit          m_last  [3];
  logic [15:0] grp [3][4];
  int          gn  [3];
  int          lasts_in  = 0;
  int          lasts_out = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a_d;
      logic [3:0]  a_k;
      logic        a_l, a_v, a_r;
      bit          take, deq;
      logic [63:0] w;
      sample(i, a_d, a_k, a_l, a_v, a_r);
      if (!nreset) begin
        m_valid[i] = 0; m_data[i] = '0; m_keep[i] = '0; m_last[i] = 0; gn[i] = 0;
      end
      chk($sformatf("u%0d out_valid", i), a_v, m_valid[i]);
      chk($sformatf("u%0d out_data", i), a_d, m_data[i]);
      chk($sformatf("u%0d out_keep", i), a_k, m_keep[i]);
      chk($sformatf("u%0d out_last", i), a_l, m_last[i]);
      chk($sformatf("u%0d in_ready", i), a_r, !m_valid[i] || ordy[i]);
      if (nreset) begin
        if (a_v && ordy[i] && a_l) lasts_out++;
        take = iv[i] && (!m_valid[i] || ordy[i]);
        deq  = m_valid[i] && ordy[i];
        if (take) begin
          grp[i][gn[i]] = id[i];
          gn[i]++;
        end
        if (take && (gn[i] == rat[i] || il[i])) begin
          w = '0;
          for (int j = 0; j < gn[i]; j++) w |= 64'(grp[i][j]) << (16 * j);
          m_data[i]  = w;
          m_keep[i]  = 4'((1 << gn[i]) - 1);
          m_last[i]  = il[i];
          m_valid[i] = 1;
          if (il[i]) lasts_in++;
          gn[i] = 0;
        end else if (deq) begin
          m_valid[i] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input logic [15:0] d, input logic l);
    id[i] = d; iv[i] = 1'b1; il[i] = l;
    tick();
    iv[i] = 1'b0; il[i] = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  took;
    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id[i] = '0; iv[i] = 1'b0; il[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (2) tick();
    chk("reset out_valid", u0_ov, 0);
    chk("reset in_ready", u0_ir, 1);
    chk("reset out_data", od2, 0);
    nreset = 1'b1;
    tick();

    // basic pack
    beat(0, 16'h1111, 0);
    beat(0, 16'h2222, 0);
    chk("basic data", od2, 32'h2222_1111);
    chk("basic keep", ok2, 2'b11);
    chk("basic last", u0_ol, 0);
    chk("basic valid", u0_ov, 1);
    tick();
    chk("basic valid pulse", u0_ov, 0);

    // early last on RATIO=4, then a full group from lane 0
    beat(1, 16'hAAAA, 0);
    beat(1, 16'hBBBB, 1);
    chk("early data", od4, 64'h0000_0000_BBBB_AAAA);
    chk("early keep", ok4, 4'b0011);
    chk("early last", u1_ol, 1);
    beat(1, 16'hCCCC, 0);
    beat(1, 16'hDDDD, 0);
    beat(1, 16'hEEEE, 0);
    beat(1, 16'hFFFF, 0);
    chk("full4 data", od4, 64'hFFFF_EEEE_DDDD_CCCC);
    chk("full4 keep", ok4, 4'b1111);
    tick();

    // RATIO=1 pass-through
    beat(2, 16'h00FF, 0);
    chk("r1 data", od1, 16'h00FF);
    chk("r1 keep", ok1, 1);
    for (int j = 1; j <= 4; j++) begin
      id[2] = 16'(j * 257); iv[2] = 1'b1;
      tick();
      chk("r1 stream data", od1, 16'(j * 257));
      chk("r1 stream valid", u2_ov, 1);
    end
    iv[2] = 1'b0;
    tick();
    chk("r1 idle valid", u2_ov, 0);

    // backpressure
    ordy[0] = 1'b0;
    beat(0, 16'h5555, 0);
    beat(0, 16'h6666, 0);
    id[0] = 16'h7777; iv[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("stall in_ready", u0_ir, 0);
      chk("stall data", od2, 32'h6666_5555);
      chk("stall valid", u0_ov, 1);
      tick();
    end
    ordy[0] = 1'b1;
    tick();
    chk("release valid", u0_ov, 0);
    id[0] = 16'h8888;
    tick();
    iv[0] = 1'b0;
    chk("release next data", od2, 32'h8888_7777);
    chk("release next valid", u0_ov, 1);
    tick();

    // reset mid-word
    beat(0, 16'h9999, 0);
    #2 nreset = 1'b0;
    #1;
    chk("midreset valid", u0_ov, 0);
    chk("midreset in_ready", u0_ir, 1);
    chk("midreset data", od2, 0);
    chk("midreset keep", ok2, 0);
    tick();
    nreset = 1'b1;
    beat(0, 16'h3333, 0);
    beat(0, 16'h4444, 0);
    chk("post reset data", od2, 32'h4444_3333);
    chk("post reset keep", ok2, 2'b11);
    tick();

    // random out_ready streaming
    for (int k = 0; k < 1000; k++) begin
      id[0] = 16'(k * 7 + 1); il[0] = (k % 16 == 15); iv[0] = 1'b1;
      cyc = 0;
      forever begin
        ordy[0] = 1'($urandom_range(0, 1));
        #1;
        took = u0_ir;
        @(posedge clk);
        #1;
        if (took) break;
        cyc++;
        if (cyc > 100) begin
          chk("stream accept timeout", 0, 1);
          break;
        end
      end
    end
    iv[0] = 1'b0; il[0] = 1'b0; ordy[0] = 1'b1;
    repeat (3) tick();
    chk("last count", 64'(lasts_out), 64'(lasts_in));
    chk("last count nonzero", 64'(lasts_out > 60), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
